// File: rtl/fault_blink_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fault_blink_pkg
// Purpose : Shared types and constants for the fault blink reporter: the FSM
//           state encoding, the pulse count shown for a zero digit, and the
//           decimal weights used by the iterative binary-to-BCD conversion.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package fault_blink_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_CONVERT    = 3'd1,
      ST_LOAD_DIGIT = 3'd2,
      ST_PULSE_ON   = 3'd3,
      ST_PULSE_OFF  = 3'd4,
      ST_DIGIT_GAP  = 3'd5,
      ST_REPEAT_GAP = 3'd6
   } blink_state_t;

   // A zero digit cannot be shown as "no pulses", so it is shown as ten.
   localparam int unsigned c_zero_digit_pulses = 10;

   localparam int unsigned c_weight_hundreds = 100;
   localparam int unsigned c_weight_tens     = 10;

   // Number of LED pulses used to display one decimal digit.
   function automatic logic [3:0] digit_pulses(input logic [3:0] digit);
      return (digit == 4'd0) ? 4'(c_zero_digit_pulses) : digit;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : tick_prescaler
// Purpose : Free-running divider producing a one-cycle tick strobe every
//           TICK_CYC clock cycles. A synchronous clear restarts the phase so
//           the first tick after a clear arrives exactly TICK_CYC cycles
//           after the clear edge.
// Ports   : clk_i   - system clock
//           rst_n_i - synchronous reset, active low
//           clear_i - restart the divider (counter returns to 0)
//           tick_o  - high for one cycle at the end of each TICK_CYC period
// Revision: 1.0 - initial release
// ============================================================================
module tick_prescaler #(
   parameter int unsigned TICK_CYC = 1_000_000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned c_cnt_w = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_CYC - 1);

   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clear_i) begin
         r_cnt <= '0;
      end else if (r_cnt == c_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick_o = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/fault_blink_reporter.sv
`default_nettype none
// ============================================================================
// Module  : fault_blink_reporter
// Purpose : Latches the first failing pin index reported by the I/O walker
//           and blinks it on one LED, one pulse group per decimal digit with
//           leading zeros suppressed, repeating forever. Also flags a clean
//           pass when the walker completes a pass with no fault latched.
// Ports   : clk_i        - system clock
//           rst_n_i      - synchronous reset, active low
//           step_valid_i - walker step result strobe
//           step_idx_i   - pin index of the step
//           step_fail_i  - step mismatch, qualified by step_valid_i
//           pass_done_i  - walker completed a full pass (strobe)
//           led_o        - registered blink output
//           fault_o      - sticky fault latched flag
//           fault_idx_o  - first failing index
//           pass_ok_o    - a pass completed and no fault is latched
//           busy_o       - reporter FSM is not idle
// Revision: 1.0 - initial release
// ============================================================================
module fault_blink_reporter
   import fault_blink_pkg::*;
#(
   parameter int unsigned NUM_PINS         = 103,
   parameter int unsigned IDX_W            = $clog2(NUM_PINS),
   parameter int unsigned TICK_CYC         = 1_000_000,
   parameter int unsigned ON_TICKS         = 2,
   parameter int unsigned OFF_TICKS        = 2,
   parameter int unsigned DIGIT_GAP_TICKS  = 6,
   parameter int unsigned REPEAT_GAP_TICKS = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             step_valid_i,
   input  logic [IDX_W-1:0] step_idx_i,
   input  logic             step_fail_i,
   input  logic             pass_done_i,
   output logic             led_o,
   output logic             fault_o,
   output logic [IDX_W-1:0] fault_idx_o,
   output logic             pass_ok_o,
   output logic             busy_o
);

   // The conversion remainder must hold the value 100 for the compare even
   // when the index itself is narrower.
   localparam int unsigned c_rem_w = (IDX_W > 7) ? IDX_W : 7;

   // The digit gap includes the off time of the last pulse, so only the
   // difference is spent in DIGIT_GAP.
   localparam int unsigned c_gap_ticks = DIGIT_GAP_TICKS - OFF_TICKS;

   localparam int unsigned c_max_a = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int unsigned c_max_b = (c_gap_ticks > REPEAT_GAP_TICKS) ? c_gap_ticks : REPEAT_GAP_TICKS;
   localparam int unsigned c_max_ticks = (c_max_a > c_max_b) ? c_max_a : c_max_b;
   localparam int unsigned c_tick_w = $clog2(c_max_ticks + 1);

   localparam logic [IDX_W:0]     c_num_pins = (IDX_W + 1)'(NUM_PINS);
   localparam logic [c_rem_w-1:0] c_hund     = c_rem_w'(c_weight_hundreds);
   localparam logic [c_rem_w-1:0] c_ten      = c_rem_w'(c_weight_tens);

   // Digit selector encoding, in display order.
   localparam logic [1:0] c_sel_hund  = 2'd0;
   localparam logic [1:0] c_sel_tens  = 2'd1;
   localparam logic [1:0] c_sel_units = 2'd2;

   blink_state_t r_state;
   blink_state_t w_state_nxt;

   logic               r_fault;
   logic [IDX_W-1:0]   r_fault_idx;
   logic               r_pass_ok;
   logic               r_led;
   logic [c_rem_w-1:0] r_rem;
   logic [3:0]         r_hund;
   logic [3:0]         r_tens;
   logic [3:0]         r_units;
   logic [1:0]         r_digit_sel;
   logic [1:0]         r_first_sel;
   logic [3:0]         r_pulses;
   logic [c_tick_w-1:0] r_ticks;

   logic                w_capture;
   logic                w_tick;
   logic                w_pre_clear;
   logic                w_phase_done;
   logic                w_conv_done;
   logic [1:0]          w_first_sel;
   logic [3:0]          w_cur_digit;
   logic [c_tick_w-1:0] w_ticks_load;
   logic [c_rem_w-1:0]  w_idx_ext;

   assign w_capture = step_valid_i && step_fail_i && !r_fault
                      && ({1'b0, step_idx_i} < c_num_pins);

   assign w_idx_ext    = c_rem_w'(step_idx_i);
   assign w_conv_done  = (r_rem < c_ten);
   assign w_phase_done = w_tick && (r_ticks == c_tick_w'(1));

   // Hundreds are shown only if nonzero; tens are shown if either they or
   // the hundreds are nonzero, so an inner zero still shows as ten pulses.
   assign w_first_sel = (r_hund != 4'd0) ? c_sel_hund :
                        (r_tens != 4'd0) ? c_sel_tens : c_sel_units;

   assign w_cur_digit = (r_digit_sel == c_sel_hund) ? r_hund :
                        (r_digit_sel == c_sel_tens) ? r_tens : r_units;

   tick_prescaler #(
      .TICK_CYC (TICK_CYC)
   ) u_prescaler (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clear_i (w_pre_clear),
      .tick_o  (w_tick)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ticks_load = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_capture) w_state_nxt = ST_CONVERT;
         end
         ST_CONVERT: begin
            if (w_conv_done) w_state_nxt = ST_LOAD_DIGIT;
         end
         ST_LOAD_DIGIT: begin
            w_state_nxt = ST_PULSE_ON;
         end
         ST_PULSE_ON: begin
            if (w_phase_done) w_state_nxt = ST_PULSE_OFF;
         end
         ST_PULSE_OFF: begin
            if (w_phase_done) begin
               w_state_nxt = (r_pulses != 4'd1) ? ST_PULSE_ON : ST_DIGIT_GAP;
            end
         end
         ST_DIGIT_GAP: begin
            if (w_phase_done) begin
               w_state_nxt = (r_digit_sel == c_sel_units) ? ST_REPEAT_GAP : ST_LOAD_DIGIT;
            end
         end
         ST_REPEAT_GAP: begin
            if (w_phase_done) w_state_nxt = ST_LOAD_DIGIT;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      case (w_state_nxt)
         ST_PULSE_ON:   w_ticks_load = c_tick_w'(ON_TICKS);
         ST_PULSE_OFF:  w_ticks_load = c_tick_w'(OFF_TICKS);
         ST_DIGIT_GAP:  w_ticks_load = c_tick_w'(c_gap_ticks);
         ST_REPEAT_GAP: w_ticks_load = c_tick_w'(REPEAT_GAP_TICKS);
         default:       w_ticks_load = '0;
      endcase
   end

   // Every transition restarts the prescaler so each phase lasts exactly
   // its tick count times TICK_CYC, regardless of where the divider was.
   assign w_pre_clear = (w_state_nxt != r_state);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_fault     <= 1'b0;
         r_fault_idx <= '0;
         r_pass_ok   <= 1'b0;
         r_led       <= 1'b0;
         r_rem       <= '0;
         r_hund      <= '0;
         r_tens      <= '0;
         r_units     <= '0;
         r_digit_sel <= c_sel_hund;
         r_first_sel <= c_sel_hund;
         r_pulses    <= '0;
         r_ticks     <= '0;
      end else begin
         // Capture has priority over a coincident pass_done.
         if (w_capture) begin
            r_fault     <= 1'b1;
            r_fault_idx <= step_idx_i;
            r_pass_ok   <= 1'b0;
         end else if (pass_done_i && !r_fault) begin
            r_pass_ok <= 1'b1;
         end

         r_led <= (w_state_nxt == ST_PULSE_ON);

         if (w_state_nxt != r_state) begin
            r_ticks <= w_ticks_load;
         end else if (w_tick) begin
            r_ticks <= r_ticks - 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_capture) begin
                  r_rem  <= w_idx_ext;
                  r_hund <= '0;
                  r_tens <= '0;
               end
            end
            ST_CONVERT: begin
               // One subtraction per cycle: hundreds first, then tens.
               if (r_rem >= c_hund) begin
                  r_rem  <= r_rem - c_hund;
                  r_hund <= r_hund + 1'b1;
               end else if (r_rem >= c_ten) begin
                  r_rem  <= r_rem - c_ten;
                  r_tens <= r_tens + 1'b1;
               end else begin
                  r_units     <= r_rem[3:0];
                  r_digit_sel <= w_first_sel;
                  r_first_sel <= w_first_sel;
               end
            end
            ST_LOAD_DIGIT: begin
               r_pulses <= digit_pulses(w_cur_digit);
            end
            ST_PULSE_OFF: begin
               if (w_phase_done) r_pulses <= r_pulses - 1'b1;
            end
            ST_DIGIT_GAP: begin
               if (w_phase_done && (r_digit_sel != c_sel_units)) begin
                  r_digit_sel <= r_digit_sel + 1'b1;
               end
            end
            ST_REPEAT_GAP: begin
               if (w_phase_done) r_digit_sel <= r_first_sel;
            end
            default: begin
            end
         endcase
      end
   end

   assign led_o       = r_led;
   assign fault_o     = r_fault;
   assign fault_idx_o = r_fault_idx;
   assign pass_ok_o   = r_pass_ok;
   assign busy_o      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fault_blink_reporter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fault_blink_reporter
// Purpose : Scoreboard bench for fault_blink_reporter. The driver applies
//           random background traffic plus directed faults, and a reference
//           model pushes the expected status per cycle and the expected LED
//           high/low run lengths per fault. Two monitors pop and compare.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fault_blink_reporter;

   localparam int NUM_PINS = 103;
   localparam int IDX_W    = 7;
   localparam int TICK_CYC = 4;
   localparam int ON_T     = 2;
   localparam int OFF_T    = 2;
   localparam int DG_T     = 6;
   localparam int RG_T     = 16;

   logic             clk        = 1'b0;
   logic             rst_n      = 1'b0;
   logic             step_valid = 1'b0;
   logic [IDX_W-1:0] step_idx   = '0;
   logic             step_fail  = 1'b0;
   logic             pass_done  = 1'b0;
   logic             led;
   logic             fault;
   logic [IDX_W-1:0] fault_idx;
   logic             pass_ok;
   logic             busy;

   always #5 clk = ~clk;

   fault_blink_reporter #(
      .NUM_PINS         (NUM_PINS),
      .IDX_W            (IDX_W),
      .TICK_CYC         (TICK_CYC),
      .ON_TICKS         (ON_T),
      .OFF_TICKS        (OFF_T),
      .DIGIT_GAP_TICKS  (DG_T),
      .REPEAT_GAP_TICKS (RG_T)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .step_valid_i (step_valid),
      .step_idx_i   (step_idx),
      .step_fail_i  (step_fail),
      .pass_done_i  (pass_done),
      .led_o        (led),
      .fault_o      (fault),
      .fault_idx_o  (fault_idx),
      .pass_ok_o    (pass_ok),
      .busy_o       (busy)
   );

   typedef struct {
      int unsigned      cyc;
      logic             fault;
      logic [IDX_W-1:0] idx;
      logic             pass_ok;
      logic             busy;
      logic             chk_led;
   } stat_t;

   typedef struct {
      logic        lvl;
      int unsigned len;
   } run_t;

   stat_t sq[$];
   run_t  rq[$];

   int          vectors     = 0;
   int          miscompares = 0;
   int unsigned cyc_cnt     = 0;

   // Reference model state.
   logic             m_fault   = 1'b0;
   logic [IDX_W-1:0] m_idx     = '0;
   logic             m_pass_ok = 1'b0;
   bit               expect_runs = 1'b1;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Expected LED waveform for two full repetitions of index n, starting at
   // the first rising edge: digit list with leading zeros dropped, each digit
   // shown as its value in pulses (zero as ten).
   function automatic void push_runs(input int n);
      int dig[$];
      int h;
      int t;
      int u;
      h = n / 100;
      t = (n / 10) % 10;
      u = n % 10;
      if (h != 0) begin
         dig.push_back(h);
         dig.push_back(t);
      end else if (t != 0) begin
         dig.push_back(t);
      end
      dig.push_back(u);
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 0; i < dig.size(); i++) begin
            int np;
            np = (dig[i] == 0) ? 10 : dig[i];
            for (int p = 1; p <= np; p++) begin
               int low;
               if (p < np)                 low = OFF_T * TICK_CYC;
               else if (i < dig.size() - 1) low = DG_T * TICK_CYC + 1;
               else                         low = (DG_T + RG_T) * TICK_CYC + 1;
               rq.push_back('{1'b1, ON_T * TICK_CYC});
               rq.push_back('{1'b0, low});
            end
         end
      end
   endfunction

   task automatic drive(input logic rn, input logic v, input logic [IDX_W-1:0] idx,
                        input logic f, input logic pd);
      stat_t s;
      @(posedge clk);
      #1;
      rst_n      = rn;
      step_valid = v;
      step_idx   = idx;
      step_fail  = f;
      pass_done  = pd;
      if (!rn) begin
         m_fault   = 1'b0;
         m_idx     = '0;
         m_pass_ok = 1'b0;
      end else if (v && f && !m_fault && (int'(idx) < NUM_PINS)) begin
         m_fault   = 1'b1;
         m_idx     = idx;
         m_pass_ok = 1'b0;
         if (expect_runs) push_runs(int'(idx));
      end else if (pd && !m_fault) begin
         m_pass_ok = 1'b1;
      end
      s.cyc     = cyc_cnt + 1;
      s.fault   = m_fault;
      s.idx     = m_idx;
      s.pass_ok = m_pass_ok;
      s.busy    = m_fault;
      s.chk_led = !m_fault;
      sq.push_back(s);
   endtask

   // Background traffic that never causes a capture on its own before a
   // fault is latched: in-range steps pass, out-of-range steps may fail.
   task automatic noise(input bit allow_pass);
      logic [IDX_W-1:0] idx;
      logic             v;
      logic             f;
      logic             pd;
      idx = IDX_W'($urandom_range(0, 127));
      v   = 1'($urandom_range(0, 1));
      f   = (m_fault || int'(idx) >= NUM_PINS) ? 1'($urandom_range(0, 1)) : 1'b0;
      pd  = allow_pass ? ($urandom_range(0, 7) == 0) : 1'b0;
      drive(1'b1, v, idx, f, pd);
   endtask

   task automatic wait_runs(input int limit);
      int k;
      k = 0;
      while (rq.size() != 0 && k < limit) begin
         noise(1'b1);
         k++;
      end
      if (rq.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL led_run_timeout pending=%0d required=0", rq.size());
         rq.delete();
      end
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic run_fault(input int idx);
      for (int i = 0; i < 5; i++) noise(1'b1);
      drive(1'b1, 1'b1, IDX_W'(idx), 1'b1, 1'b0);
      wait_runs(3000);
      do_reset(2);
   endtask

   // Status monitor: compares the registered outputs against the model
   // entry scheduled for this cycle.
   initial begin
      stat_t s;
      forever begin
         @(posedge clk);
         #2;
         while (sq.size() != 0 && sq[0].cyc < cyc_cnt) void'(sq.pop_front());
         if (sq.size() != 0 && sq[0].cyc == cyc_cnt) begin
            s = sq.pop_front();
            vectors++;
            if (fault !== s.fault || fault_idx !== s.idx || pass_ok !== s.pass_ok ||
                busy !== s.busy || (s.chk_led && led !== 1'b0)) begin
               miscompares++;
               $display("FAIL status cyc=%0d got fault=%b idx=%0d pass_ok=%b busy=%b led=%b required fault=%b idx=%0d pass_ok=%b busy=%b led=%s",
                        cyc_cnt, fault, fault_idx, pass_ok, busy, led,
                        s.fault, s.idx, s.pass_ok, s.busy, s.chk_led ? "0" : "-");
            end
         end
      end
   end

   // LED run monitor: measures each completed high/low run after the first
   // rising edge since reset and compares it with the expected run queue.
   initial begin
      logic        prev_led;
      int unsigned run_len;
      bit          armed;
      run_t        r;
      prev_led = 1'b0;
      run_len  = 0;
      armed    = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            armed    = 1'b0;
            run_len  = 0;
            prev_led = led;
         end else if (led !== prev_led) begin
            if (armed && rq.size() != 0) begin
               r = rq.pop_front();
               vectors++;
               if (r.lvl !== prev_led || r.len != run_len) begin
                  miscompares++;
                  $display("FAIL led_run got level=%b len=%0d required level=%b len=%0d",
                           prev_led, run_len, r.lvl, r.len);
               end
            end
            if (led === 1'b1) armed = 1'b1;
            prev_led = led;
            run_len  = 1;
         end else begin
            run_len++;
         end
      end
   end

   initial begin
      int k;
      do_reset(3);

      run_fault(0);
      run_fault(57);
      run_fault(102);

      // Second fault must be ignored: display stays 1, 2.
      for (int i = 0; i < 3; i++) noise(1'b1);
      drive(1'b1, 1'b1, IDX_W'(12), 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) noise(1'b1);
      drive(1'b1, 1'b1, IDX_W'(40), 1'b1, 1'b0);
      wait_runs(3000);
      do_reset(2);

      // Three clean passes, then a fault coincident with pass_done.
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 4; i++) noise(1'b0);
         drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
      end
      for (int i = 0; i < 3; i++) noise(1'b0);
      drive(1'b1, 1'b1, IDX_W'(3), 1'b1, 1'b1);
      wait_runs(3000);
      do_reset(2);

      // Out-of-range fail is not captured.
      drive(1'b1, 1'b1, IDX_W'(103), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) noise(1'b1);

      // Real fault, then reset while the LED is high.
      expect_runs = 1'b0;
      drive(1'b1, 1'b1, IDX_W'(77), 1'b1, 1'b0);
      k = 0;
      while (led !== 1'b1 && k < 500) begin
         noise(1'b1);
         k++;
      end
      if (led !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL led_rise_timeout got led=%b required 1", led);
      end
      for (int i = 0; i < 3; i++) noise(1'b1);
      do_reset(2);
      for (int i = 0; i < 4; i++) noise(1'b1);
      expect_runs = 1'b1;

      // Random in-range fault indices.
      for (int n = 0; n < 3; n++) run_fault($urandom_range(0, NUM_PINS - 1));

      for (int i = 0; i < 3; i++) noise(1'b0);
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
